rpm_multiplier_seq: RTL and testbench

//  Iterative, parametrised Russian peasant (shift-add) multiplier.
//  - Processes one multiplier bit per cycle.
//  - Terminates early once the remaining multiplier bits are zero.
//  - Supports unsigned and signed (two's complement) operands, selected per operation.
//  - Sits between a producer and a consumer on valid/ready streams; replaces the

---
 rtl/rpm_multiplier_seq.sv | 139 +++++++++++++
 tb/tb_rpm_multiplier_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpm_multiplier_seq.sv
// rpm_multiplier_seq
//   Iterative Russian-peasant (shift-add) multiplier. It retires one multiplier
//   bit per cycle and stops early once the remaining multiplier bits are zero.
//   Operands may be unsigned or two's complement, selected per operation.
//   The core multiplies magnitudes and applies the sign once at the end.
//
// Parameters
//   WIDTH      operand width in bits (>= 2); the product is 2*WIDTH bits
//   SIGNED_EN  1: in_signed is honoured; 0: every operation is unsigned
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand pair presented by the producer
//   in_ready   operands accepted this cycle (high only in IDLE)
//   a          multiplicand
//   b          multiplier
//   in_signed  1: a and b are two's complement
//   out_valid  product valid, held until out_ready
//   out_ready  consumer accepts the product
//   product    result, two's complement for signed operations
//   busy       an operation is in RUN or DONE
module rpm_multiplier_seq #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mc_q;
  logic [WIDTH-1:0]     mp_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic                 sg;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 last_d;

  // Operand conditioning for the load in IDLE. Negating the most negative
  // value wraps back to the same bit pattern, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  always_comb begin
    sg    = (SIGNED_EN != 0) && in_signed;
    a_abs = (sg && a[WIDTH-1]) ? ('0 - a) : a;
    b_abs = (sg && b[WIDTH-1]) ? ('0 - b) : b;
  end

  // One shift-add step; the step is final once no set multiplier bits remain
  // above the one being consumed now.
  always_comb begin
    acc_d  = mp_q[0] ? (acc_q + mc_q) : acc_q;
    last_d = (mp_q[WIDTH-1:1] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mc_q        <= '0;
      mp_q        <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mc_q       <= {{WIDTH{1'b0}}, a_abs};
            mp_q       <= b_abs;
            acc_q      <= '0;
            neg_q      <= sg && (a[WIDTH-1] ^ b[WIDTH-1]);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end

        S_RUN: begin
          mc_q  <= mc_q << 1;
          mp_q  <= mp_q >> 1;
          acc_q <= acc_d;
          if (last_d) begin
            // A zero magnitude negates to zero, so no negative zero appears.
            product_q   <= neg_q ? ('0 - acc_d) : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rpm_multiplier_seq.sv
module tb_rpm_multiplier_seq;

  localparam int NOPS = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, signed-capable instance
  logic        iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b0, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;

  // 8-bit instance with signed support disabled
  logic        ivu = 1'b0, iru, su = 1'b0, ovu, oru = 1'b0, busyu;
  logic [7:0]  au = '0, bu = '0;
  logic [15:0] produ;

  // 16-bit, signed-capable instance
  logic        iv16 = 1'b0, ir16, s16 = 1'b0, ov16, or16 = 1'b0, busy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] prod16;

  rpm_multiplier_seq #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .in_signed(s8), .out_valid(ov8), .out_ready(or8), .product(prod8), .busy(busy8)
  );

  rpm_multiplier_seq #(.WIDTH(8), .SIGNED_EN(0)) u_dutu (
    .clk(clk), .rst(rst), .in_valid(ivu), .in_ready(iru), .a(au), .b(bu),
    .in_signed(su), .out_valid(ovu), .out_ready(oru), .product(produ), .busy(busyu)
  );

  rpm_multiplier_seq #(.WIDTH(16), .SIGNED_EN(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .in_signed(s16), .out_valid(ov16), .out_ready(or16), .product(prod16), .busy(busy16)
  );

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sg);
    longint sx, sy, p;
    sx = sg ? longint'($signed(x)) : longint'(x);
    sy = sg ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic sg);
    longint sx, sy, p;
    sx = sg ? longint'($signed(x)) : longint'(x);
    sy = sg ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[31:0];
  endfunction

  // Stimulus only: issue one operation on the 8-bit instance, count RUN cycles
  // until out_valid, capture the product and optionally accept it.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                         input bit release_out, output int cyc, output logic [15:0] p,
                         output bit ok, output bit ir_bad);
    int w;
    w = 0; cyc = 0; ok = 1'b1; ir_bad = 1'b0;
    while (!ir8 && w < 50) begin @(posedge clk); #1; w++; end
    if (!ir8) ok = 1'b0;
    a8 = ta; b8 = tb; s8 = ts; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    if (ir8) ir_bad = 1'b1;
    while (!ov8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ir8) ir_bad = 1'b1;
    end
    if (!ov8) ok = 1'b0;
    p = prod8;
    if (release_out) begin
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || prod8 !== 16'h0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h busy=%b, need 1 0 0000 0", ir8, ov8, prod8, busy8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int cyc; logic [15:0] p; bit ok, irb;
    logic [7:0] va[4] = '{8'd13, 8'd255, 8'd7,  8'd251};
    logic [7:0] vb[4] = '{8'd11, 8'd255, 8'd0,  8'd3};
    int         vc[4] = '{4, 8, 1, 2};
    logic [15:0] vp[4] = '{16'd143, 16'hFE01, 16'h0000, 16'd753};
    for (int i = 0; i < 4; i++) begin
      run_op8(va[i], vb[i], 1'b0, 1'b1, cyc, p, ok, irb);
      checks++;
      if (!ok || cyc != vc[i] || p !== vp[i] || irb) begin
        errors++;
        $display("FAIL unsigned %0d*%0d: product=%h cycles=%0d done=%b in_ready_high=%b, need product=%h cycles=%0d", va[i], vb[i], p, cyc, ok, irb, vp[i], vc[i]);
      end
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL unsigned_release %0d: out_valid=%b in_ready=%b busy=%b, need 0 1 0", i, ov8, ir8, busy8);
      end
    end
  endtask

  task automatic test_signed();
    int cyc, w; logic [15:0] p; bit ok, irb;
    logic [7:0] va[4] = '{8'h80, 8'hFB, 8'h80, 8'h05};
    logic [7:0] vb[4] = '{8'h80, 8'h03, 8'h7F, 8'hFD};
    int         vc[4] = '{8, 2, 7, 2};
    logic [15:0] vp[4] = '{16'h4000, 16'hFFF1, 16'hC080, 16'hFFF1};
    for (int i = 0; i < 4; i++) begin
      run_op8(va[i], vb[i], 1'b1, 1'b1, cyc, p, ok, irb);
      checks++;
      if (!ok || cyc != vc[i] || p !== vp[i] || irb) begin
        errors++;
        $display("FAIL signed %h*%h: product=%h cycles=%0d done=%b in_ready_high=%b, need product=%h cycles=%0d", va[i], vb[i], p, cyc, ok, irb, vp[i], vc[i]);
      end
    end
    // in_signed ignored when signed support is disabled: 251*3 unsigned
    au = 8'hFB; bu = 8'h03; su = 1'b1; ivu = 1'b1;
    @(posedge clk); #1;
    ivu = 1'b0;
    w = 0;
    while (!ovu && w < 100) begin @(posedge clk); #1; w++; end
    checks++;
    if (ovu !== 1'b1 || produ !== 16'h02F1) begin
      errors++;
      $display("FAIL signed_disabled: out_valid=%b product=%h, need 1 02f1", ovu, produ);
    end
    oru = 1'b1;
    @(posedge clk); #1;
    oru = 1'b0; su = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc; logic [15:0] p; bit ok, irb;
    run_op8(8'd6, 8'd5, 1'b0, 1'b0, cyc, p, ok, irb);
    checks++;
    if (!ok || p !== 16'd30) begin
      errors++;
      $display("FAIL bp_result: product=%h done=%b, need 001e 1", p, ok);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b1 || prod8 !== 16'd30 || ir8 !== 1'b0 || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b product=%h in_ready=%b busy=%b, need 1 001e 0 1", i, ov8, prod8, ir8, busy8);
      end
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0 || prod8 !== 16'd30) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b product=%h, need 0 1 0 001e", ov8, ir8, busy8, prod8);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, seen; logic [15:0] p; bit ok, irb;
    a8 = 8'd200; b8 = 8'd200; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_start: busy=%b in_ready=%b, need 1 0", busy8, ir8);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || prod8 !== 16'h0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b product=%h busy=%b, need 1 0 0000 0", ir8, ov8, prod8, busy8);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_discard: out_valid cycles=%0d, need 0", seen);
    end
    run_op8(8'd3, 8'd4, 1'b0, 1'b1, cyc, p, ok, irb);
    checks++;
    if (!ok || p !== 16'd12 || cyc != 3) begin
      errors++;
      $display("FAIL rst_mid_next: product=%h cycles=%0d done=%b, need 000c 3 1", p, cyc, ok);
    end
  endtask

  task automatic test_stream8();
    logic [15:0] q[$];
    int sent = 0, recv = 0;
    bit acc, hs;
    logic [15:0] got, exp_p;
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b0;
    for (int c = 0; c < 4000 && recv < NOPS; c++) begin
      @(negedge clk);
      acc = iv8 && ir8;
      hs  = ov8 && or8;
      got = prod8;
      if (acc) begin q.push_back(ref8(a8, b8, s8)); sent++; end
      if (hs) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream8 unexpected product=%h", got);
        end else begin
          exp_p = q.pop_front();
          if (got !== exp_p) begin
            errors++;
            $display("FAIL stream8 op %0d: product=%h, need %h", recv, got, exp_p);
          end
        end
        recv++;
      end
      @(posedge clk); #1;
      if (!iv8 || acc) begin
        if (sent < NOPS && $urandom_range(0, 1) == 1) begin
          a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); iv8 = 1'b1;
        end else iv8 = 1'b0;
      end
      or8 = ($urandom_range(0, 3) != 0);
    end
    iv8 = 1'b0; or8 = 1'b0;
    checks++;
    if (recv != NOPS || q.size() != 0) begin
      errors++;
      $display("FAIL stream8_count: received=%0d pending=%0d, need %0d 0", recv, q.size(), NOPS);
    end
  endtask

  task automatic test_stream16();
    logic [31:0] q[$];
    int sent = 0, recv = 0;
    bit acc, hs;
    logic [31:0] got, exp_p;
    @(posedge clk); #1;
    iv16 = 1'b0; or16 = 1'b0;
    for (int c = 0; c < 4000 && recv < NOPS; c++) begin
      @(negedge clk);
      acc = iv16 && ir16;
      hs  = ov16 && or16;
      got = prod16;
      if (acc) begin q.push_back(ref16(a16, b16, s16)); sent++; end
      if (hs) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream16 unexpected product=%h", got);
        end else begin
          exp_p = q.pop_front();
          if (got !== exp_p) begin
            errors++;
            $display("FAIL stream16 op %0d: product=%h, need %h", recv, got, exp_p);
          end
        end
        recv++;
      end
      @(posedge clk); #1;
      if (!iv16 || acc) begin
        if (sent < NOPS && $urandom_range(0, 1) == 1) begin
          a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom); iv16 = 1'b1;
        end else iv16 = 1'b0;
      end
      or16 = ($urandom_range(0, 3) != 0);
    end
    iv16 = 1'b0; or16 = 1'b0;
    checks++;
    if (recv != NOPS || q.size() != 0) begin
      errors++;
      $display("FAIL stream16_count: received=%0d pending=%0d, need %0d 0", recv, q.size(), NOPS);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
    test_stream8();
    test_stream16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
